// File: rtl/gshare_predictor_param.sv
// Parametrised gshare direction predictor: PC^GHR indexed PHT of saturating counters,
// decoupled predict/train ports, checkpointed history repair and saturating statistics.
module gshare_predictor_param #(
    parameter int PC_W     = 8,
    parameter int IDX_W    = 8,
    parameter int GHR_W    = 8,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 1,
    parameter int STAT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    output logic              o_ready,
    input  logic              i_req_valid,
    input  logic [PC_W-1:0]   i_req_pc,
    output logic              o_pred_valid,
    output logic              o_pred_taken,
    output logic [IDX_W-1:0]  o_pred_idx,
    output logic [GHR_W-1:0]  o_pred_ghr,
    input  logic              i_upd_valid,
    input  logic [IDX_W-1:0]  i_upd_idx,
    input  logic [GHR_W-1:0]  i_upd_ghr,
    input  logic              i_upd_pred,
    input  logic              i_upd_taken,
    output logic [STAT_W-1:0] o_stat_updates,
    output logic [STAT_W-1:0] o_stat_mispred
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [GHR_W-1:0]  r_ghr;
    logic [CTR_W-1:0]  r_pht [DEPTH];
    logic              r_pred_valid;
    logic              r_pred_taken;
    logic [IDX_W-1:0]  r_pred_idx;
    logic [GHR_W-1:0]  r_pred_ghr;
    logic [STAT_W-1:0] r_stat_upd;
    logic [STAT_W-1:0] r_stat_mis;

    logic              w_run;
    logic [IDX_W-1:0]  w_idx;
    logic              w_pred_bit;
    logic              w_mispred;
    logic [CTR_W-1:0]  w_upd_ctr;
    logic [CTR_W-1:0]  w_upd_nxt;
    logic              w_unused;

    assign w_run      = (r_state == S_RUN);
    assign w_idx      = i_req_pc[IDX_W-1:0] ^ IDX_W'(r_ghr);
    assign w_pred_bit = r_pht[w_idx][CTR_W-1];
    assign w_mispred  = i_upd_pred != i_upd_taken;
    assign w_upd_ctr  = r_pht[i_upd_idx];
    assign w_upd_nxt  = ( i_upd_taken && w_upd_ctr != CTR_MAX) ? w_upd_ctr + CTR_W'(1) :
                        (!i_upd_taken && w_upd_ctr != '0)      ? w_upd_ctr - CTR_W'(1) :
                                                                 w_upd_ctr;
    // PC bits above the index and the checkpoint MSB play no part in prediction.
    assign w_unused   = ^{i_req_pc, i_upd_ghr[GHR_W-1]};

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= S_INIT;
            r_ptr        <= '0;
            r_ghr        <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= '0;
            r_pred_ghr   <= '0;
            r_stat_upd   <= '0;
            r_stat_mis   <= '0;
        end else begin
            r_pred_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_ptr <= r_ptr + IDX_W'(1);
                    if (r_ptr == PTR_LAST) r_state <= S_RUN;
                end
                default: begin
                    if (i_req_valid) begin
                        r_pred_valid <= 1'b1;
                        r_pred_taken <= w_pred_bit;
                        r_pred_idx   <= w_idx;
                        r_pred_ghr   <= r_ghr;
                    end
                    // Checkpoint repair wins over the same-cycle speculative shift.
                    if (i_upd_valid && w_mispred)
                        r_ghr <= {i_upd_ghr[GHR_W-2:0], i_upd_taken};
                    else if (i_req_valid)
                        r_ghr <= {r_ghr[GHR_W-2:0], w_pred_bit};
                    if (i_upd_valid) begin
                        if (r_stat_upd != '1) r_stat_upd <= r_stat_upd + STAT_W'(1);
                        if (w_mispred && r_stat_mis != '1) r_stat_mis <= r_stat_mis + STAT_W'(1);
                    end
                end
            endcase
        end
    end

    // PHT has no reset; the sweep fills it before requests are honoured.
    always_ff @(posedge i_clk) begin
        if (i_reset_n) begin
            if (r_state == S_INIT)
                r_pht[r_ptr] <= CTR_INIT;
            else if (i_upd_valid)
                r_pht[i_upd_idx] <= w_upd_nxt;
        end
    end

    assign o_ready        = w_run;
    assign o_pred_valid   = r_pred_valid;
    assign o_pred_taken   = r_pred_taken;
    assign o_pred_idx     = r_pred_idx;
    assign o_pred_ghr     = r_pred_ghr;
    assign o_stat_updates = r_stat_upd;
    assign o_stat_mispred = r_stat_mis;
endmodule

// File: doc/gshare_predictor_param.md
# gshare_predictor_param

Parametrised gshare branch direction predictor, the successor to the fixed 8-bit gshare block. PC width, history length, table depth and counter width are parameters. Prediction and training use separate ports, so a branch can resolve several cycles after it was predicted. Speculative global history is repaired from a per-prediction history checkpoint on mispredict. The PHT is initialised by a sweep after reset, and the block keeps saturating update and mispredict statistics for the fetch-stage bench.

## Interface
- PC_W, 8, PC bits presented; must be ≥ IDX_W
- IDX_W, 8, PHT index width; table depth = 2^IDX_W
- GHR_W, 8, global history length; 2 ≤ GHR_W ≤ IDX_W
- CTR_W, 2, saturating counter width; prediction = counter MSB
- INIT_CTR, 1, counter value written by init sweep (weakly not-taken for CTR_W=2)
- STAT_W, 16, statistics counter width

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  reset; synchronous, active-low
- ready  out  1  high when the PHT sweep is complete and requests are accepted
- req_valid  in  1  prediction request
- req_pc  in  PC_W  branch PC
- pred_valid  out  1  prediction result valid, one cycle after the accepted request
- pred_taken  out  1  predicted direction
- pred_idx  out  IDX_W  PHT index used; the caller returns it on update
- pred_ghr  out  GHR_W  GHR value used (checkpoint); the caller returns it on update
- upd_valid  in  1  resolved branch
- upd_idx  in  IDX_W  index from pred_idx
- upd_ghr  in  GHR_W  checkpoint from pred_ghr
- upd_pred  in  1  direction that was predicted
- upd_taken  in  1  actual direction
- stat_updates  out  STAT_W  accepted updates, saturating
- stat_mispred  out  STAT_W  accepted updates with upd_pred≠upd_taken, saturating

## Operation
- Index = req_pc[IDX_W-1:0] XOR {zeros, GHR}, with GHR zero-extended into the low bits.
- FSM states:
  - INIT: sweep pointer runs 0..2^IDX_W−1, one entry written with INIT_CTR per cycle. After the last write, go to RUN.
  - RUN: ready=1.
  - Reset (asserted in any state, including mid-sweep) returns to INIT with pointer 0.
- In INIT, req_valid and upd_valid are ignored: no GHR change, no PHT change, no stats change.
- Predict (RUN, req_valid):
  - Latch pred_taken = MSB of PHT[index], pred_idx = index, pred_ghr = current GHR.
  - GHR ← {GHR[GHR_W-2:0], predicted bit}.
- Update (RUN, upd_valid):
  - PHT[upd_idx] increments if taken, decrements if not taken, saturating at 0 and 2^CTR_W−1.
  - stat_updates += 1.
  - If upd_pred≠upd_taken: stat_mispred += 1 and GHR ← {upd_ghr[GHR_W-2:0], upd_taken}.
- Stats saturate at all-ones and never wrap.
- Simultaneous predict and update, same cycle:
  - The prediction reads the pre-update counter (no bypass).
  - A mispredict repair overrides the speculative GHR shift. The prediction issued that cycle is still reported with pred_ghr = pre-repair GHR, and the caller discards it as wrong-path.
  - If there is no mispredict, the predict shift applies.
- Counter arithmetic is CTR_W bits wide; GHR shifts discard the MSB.

## Timing
- Reset values: ready=0, pred_valid=0, pred_taken=0, pred_idx=0, pred_ghr=0, GHR=0, stat_updates=0, stat_mispred=0.
- The PHT is not reset directly; it is written by the sweep.
- The cycle after reset_n is sampled high, the sweep runs for 2^IDX_W cycles. ready rises on the edge that writes the last entry plus one, i.e. it is observed high 2^IDX_W cycles after reset release.
- Prediction latency is 1 cycle. pred_valid is a single-cycle pulse per accepted request, and back-to-back requests give back-to-back results.
- An update takes effect at the next edge. A prediction to the same index in the following cycle sees the new counter.
- There is no backpressure on either port in RUN: one request and one update are accepted per cycle.

## Test plan
- Init: IDX_W=4, release reset. ready must be 0 for exactly 16 cycles, then 1. A request with pc=0x00 then gives pred_taken=0 and pred_idx=0.
- Training: GHR=0. Issue 3 updates to idx 5 with taken=1, upd_pred=0; the counter goes 1→2→3→3 (saturates). A request with pc=0x05 gives pred_taken=1. Then 4 updates with taken=0; the counter reaches 0 and pred_taken=0.
- Speculative history: with PHT at init, predict pc=0x10 three times. pred_ghr must read 0x00,0x00,0x00 and pred_idx 0x10,0x10,0x10 (all predicted 0). After a forced taken training of idx 0x10, the next predict gives pred_ghr=0x00 and the one after gives pred_ghr=0x01.
- Repair: update with upd_ghr=0xA5, upd_pred=0, upd_taken=1 while a predict arrives the same cycle. The next prediction must use GHR=0x4B; stat_mispred increments by 1.
- Stats saturation: STAT_W=4. Issue 20 updates with mispredicts; both stats must read 15 and hold.
- Reset mid-sweep: deassert reset_n 5 cycles into INIT. ready must stay 0, and the sweep must restart, giving the full 2^IDX_W cycles after the new release. Requests during INIT produce no pred_valid.
